// File: rtl/axi_master_bridge.sv
// AXI4 initiator: turns one core-side read/write request into a single INCR burst,
// streams the data beats through, and reports completion with an error flag.
module axi_master_bridge #(
    parameter logic [3:0]  AXI_ID = 4'd0,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [31:0]           req_addr_i,
    input  logic [7:0]            req_len_i,
    input  logic [2:0]            req_size_i,
    input  logic                  wd_valid_i,
    input  logic [DATA_W-1:0]     wd_data_i,
    input  logic [DATA_W/8-1:0]   wd_strb_i,
    output logic                  wd_ready_o,
    output logic                  rd_valid_o,
    output logic [DATA_W-1:0]     rd_data_o,
    output logic                  rd_last_o,
    input  logic                  rd_ready_i,
    output logic                  done_o,
    output logic                  err_o,
    output logic [3:0]            arid_o,
    output logic [31:0]           araddr_o,
    output logic [7:0]            arlen_o,
    output logic [2:0]            arsize_o,
    output logic [1:0]            arburst_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    input  logic [3:0]            rid_i,
    input  logic [DATA_W-1:0]     rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rlast_i,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    output logic [3:0]            awid_o,
    output logic [31:0]           awaddr_o,
    output logic [7:0]            awlen_o,
    output logic [2:0]            awsize_o,
    output logic [1:0]            awburst_o,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [DATA_W-1:0]     wdata_o,
    output logic [DATA_W/8-1:0]   wstrb_o,
    output logic                  wlast_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    input  logic [3:0]            bid_i,
    input  logic [1:0]            bresp_i,
    input  logic                  bvalid_i,
    output logic                  bready_o
);

    localparam int unsigned CNT_W = 8;

    typedef enum logic [6:0] {
        S_IDLE = 7'b0000001,
        S_AR   = 7'b0000010,
        S_R    = 7'b0000100,
        S_AW   = 7'b0001000,
        S_W    = 7'b0010000,
        S_B    = 7'b0100000,
        S_DONE = 7'b1000000
    } state_t;

    state_t             state, state_nx;
    logic [31:0]        addr_q;
    logic [CNT_W-1:0]   len_q;
    logic [CNT_W-1:0]   count_q;
    logic [2:0]         size_q;
    logic               err_q;
    logic               last_beat;
    logic               r_hs;
    logic               w_hs;
    logic               unused_ids;

    assign last_beat = (count_q == len_q);
    assign r_hs      = (state == S_R) && rvalid_i && rd_ready_i;
    assign w_hs      = (state == S_W) && wd_valid_i && wready_i;
    assign unused_ids = ^{rid_i, bid_i};

    // Burst descriptor is held in registers so address channels stay stable under stall.
    assign arid_o    = AXI_ID;
    assign araddr_o  = addr_q;
    assign arlen_o   = len_q;
    assign arsize_o  = size_q;
    assign arburst_o = 2'b01;
    assign awid_o    = AXI_ID;
    assign awaddr_o  = addr_q;
    assign awlen_o   = len_q;
    assign awsize_o  = size_q;
    assign awburst_o = 2'b01;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Request latch, beat counter and sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            if (state == S_IDLE && req_valid_i) begin
                addr_q  <= req_addr_i;
                len_q   <= req_len_i;
                size_q  <= req_size_i;
                count_q <= '0;
                err_q   <= 1'b0;
            end
            if (r_hs) begin
                count_q <= count_q + CNT_W'(1);
                if (rresp_i != 2'b00 || rlast_i != last_beat) begin
                    err_q <= 1'b1;
                end
            end
            if (w_hs) begin
                count_q <= count_q + CNT_W'(1);
            end
            if (state == S_B && bvalid_i && bresp_i != 2'b00) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        req_ready_o = 1'b0;
        arvalid_o   = 1'b0;
        awvalid_o   = 1'b0;
        rready_o    = 1'b0;
        rd_valid_o  = 1'b0;
        rd_data_o   = '0;
        rd_last_o   = 1'b0;
        wvalid_o    = 1'b0;
        wdata_o     = '0;
        wstrb_o     = '0;
        wlast_o     = 1'b0;
        wd_ready_o  = 1'b0;
        bready_o    = 1'b0;
        done_o      = 1'b0;
        err_o       = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_nx = req_we_i ? S_AW : S_AR;
                end
            end
            S_AR: begin
                arvalid_o = 1'b1;
                if (arready_i) state_nx = S_R;
            end
            S_R: begin
                rready_o   = rd_ready_i;
                rd_valid_o = rvalid_i;
                rd_data_o  = rdata_i;
                rd_last_o  = last_beat;
                if (r_hs && last_beat) state_nx = S_DONE;
            end
            S_AW: begin
                awvalid_o = 1'b1;
                if (awready_i) state_nx = S_W;
            end
            S_W: begin
                wvalid_o   = wd_valid_i;
                wd_ready_o = wready_i;
                wdata_o    = wd_data_i;
                wstrb_o    = wd_strb_i;
                wlast_o    = last_beat;
                if (w_hs && last_beat) state_nx = S_B;
            end
            S_B: begin
                bready_o = 1'b1;
                if (bvalid_i) state_nx = S_DONE;
            end
            S_DONE: begin
                done_o   = 1'b1;
                err_o    = err_q;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_axi_master_bridge.sv
// Self-checking bench for axi_master_bridge: procedural responder/producer with a beat scoreboard.
module tb_axi_master_bridge;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i, req_ready_o, req_we_i;
    logic [31:0] req_addr_i;
    logic [7:0]  req_len_i;
    logic [2:0]  req_size_i;
    logic        wd_valid_i, wd_ready_o;
    logic [31:0] wd_data_i;
    logic [3:0]  wd_strb_i;
    logic        rd_valid_o, rd_last_o, rd_ready_i;
    logic [31:0] rd_data_o;
    logic        done_o, err_o;
    logic [3:0]  arid_o, awid_o, rid_i, bid_i;
    logic [31:0] araddr_o, awaddr_o, rdata_i, wdata_o;
    logic [7:0]  arlen_o, awlen_o;
    logic [2:0]  arsize_o, awsize_o;
    logic [1:0]  arburst_o, awburst_o, rresp_i, bresp_i;
    logic        arvalid_o, arready_i, rlast_i, rvalid_i, rready_o;
    logic        awvalid_o, awready_i;
    logic [3:0]  wstrb_o;
    logic        wlast_o, wvalid_o, wready_i;
    logic        bvalid_i, bready_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [63:0] sb_q[$];

    axi_master_bridge dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_len_i(req_len_i), .req_size_i(req_size_i),
        .wd_valid_i(wd_valid_i), .wd_data_i(wd_data_i), .wd_strb_i(wd_strb_i), .wd_ready_o(wd_ready_o),
        .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_last_o(rd_last_o), .rd_ready_i(rd_ready_i),
        .done_o(done_o), .err_o(err_o),
        .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
        .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
        .rvalid_i(rvalid_i), .rready_o(rready_o),
        .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
        .awburst_o(awburst_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        req_valid_i = 0; req_we_i = 0; req_addr_i = '0; req_len_i = '0; req_size_i = '0;
        wd_valid_i = 0; wd_data_i = '0; wd_strb_i = '0; rd_ready_i = 0;
        arready_i = 0; rid_i = '0; rdata_i = '0; rresp_i = '0; rlast_i = 0; rvalid_i = 0;
        awready_i = 0; wready_i = 0; bid_i = '0; bresp_i = '0; bvalid_i = 0;
    endtask

    task automatic run_read(input logic [31:0] addr, input logic [7:0] len, input bit toggle,
                            input int bad_last, input int bad_resp, input int ar_stall, input bit exp_err);
        int lat, b, guard;
        logic [63:0] e;
        @(negedge clk_i);
        req_valid_i = 1; req_we_i = 0; req_addr_i = addr; req_len_i = len; req_size_i = 3'd2;
        #1 check("rd_req_ready", 64'(req_ready_o), 1);
        @(posedge clk_i);
        lat = 0;
        @(negedge clk_i);
        req_valid_i = 0;
        for (int c = 0; c <= ar_stall; c++) begin
            arready_i = (c == ar_stall);
            #1;
            check("arvalid", 64'(arvalid_o), 1);
            check("araddr", 64'(araddr_o), 64'(addr));
            check("arlen", 64'(arlen_o), 64'(len));
            check("arsize", 64'(arsize_o), 2);
            check("arburst", 64'(arburst_o), 1);
            if (c < ar_stall) check("ar_stall_quiet", 64'({awvalid_o, wvalid_o, rready_o, rd_valid_o}), 0);
            @(posedge clk_i); lat++; @(negedge clk_i);
        end
        arready_i = 0;
        b = 0; guard = 0;
        while (b <= int'(len) && guard < 600) begin
            rvalid_i   = 1;
            rdata_i    = 32'hDEADBEEF + 32'(b) * 32'h01010101;
            rlast_i    = (b == int'(len)) || (b == bad_last);
            rresp_i    = (b == bad_resp) ? 2'b11 : 2'b00;
            rd_ready_i = toggle ? (guard % 2 == 0) : 1'b1;
            if (sb_q.size() == 0) sb_q.push_back({31'd0, (b == int'(len)), rdata_i});
            #1;
            check("rready_mirror", 64'(rready_o), 64'(rd_ready_i));
            check("rd_valid", 64'(rd_valid_o), 1);
            if (rd_ready_i) begin
                e = sb_q.pop_front();
                check("rd_beat", {31'd0, rd_last_o, rd_data_o}, e);
                b++;
            end
            @(posedge clk_i); lat++; guard++; @(negedge clk_i);
        end
        if (guard >= 600) check("r_timeout", 0, 1);
        rvalid_i = 0; rlast_i = 0; rresp_i = 0; rd_ready_i = 0;
        #1;
        check("rd_done", 64'(done_o), 1);
        check("rd_err", 64'(err_o), 64'(exp_err));
        if (!toggle && ar_stall == 0) check("rd_latency", 64'(lat + 1), 64'(3 + int'(len)));
        @(negedge clk_i);
        #1;
        check("rd_done_pulse", 64'(done_o), 0);
        check("rd_idle_ready", 64'(req_ready_o), 1);
        sb_q.delete();
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [7:0] len, input int gap,
                             input logic [1:0] bresp, input bit exp_err, input int rst_beat);
        int lat, b, guard, gcnt;
        logic [63:0] e;
        @(negedge clk_i);
        req_valid_i = 1; req_we_i = 1; req_addr_i = addr; req_len_i = len; req_size_i = 3'd2;
        #1 check("wr_req_ready", 64'(req_ready_o), 1);
        @(posedge clk_i);
        lat = 0;
        @(negedge clk_i);
        req_valid_i = 0; req_we_i = 0;
        awready_i = 1;
        #1;
        check("awvalid", 64'(awvalid_o), 1);
        check("awaddr", 64'(awaddr_o), 64'(addr));
        check("awlen", 64'(awlen_o), 64'(len));
        check("awburst", 64'(awburst_o), 1);
        check("aw_ar_quiet", 64'(arvalid_o), 0);
        @(posedge clk_i); lat++; @(negedge clk_i);
        awready_i = 0;
        b = 0; guard = 0; gcnt = 0;
        while (b <= int'(len) && guard < 600) begin
            if (b == rst_beat) begin
                wd_valid_i = 0; wready_i = 0;
                rst_i = 1;
                @(posedge clk_i); @(negedge clk_i);
                rst_i = 0;
                #1;
                check("rst_valids", 64'({arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o,
                                         rd_valid_o, wd_ready_o, done_o}), 0);
                check("rst_req_ready", 64'(req_ready_o), 1);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk_i); #1 check("rst_no_done", 64'(done_o), 0);
                end
                sb_q.delete();
                return;
            end
            wready_i   = 1;
            wd_valid_i = (gcnt == 0);
            wd_data_i  = 32'hA5A50000 | 32'(b);
            wd_strb_i  = 4'(b + 1);
            if (wd_valid_i) sb_q.push_back({27'd0, (b == int'(len)), wd_strb_i, wd_data_i});
            #1;
            check("wvalid_mirror", 64'(wvalid_o), 64'(wd_valid_i));
            check("wd_ready", 64'(wd_ready_o), 1);
            check("w_bready_low", 64'(bready_o), 0);
            if (wd_valid_i) begin
                e = sb_q.pop_front();
                check("w_beat", {27'd0, wlast_o, wstrb_o, wdata_o}, e);
                b++;
                gcnt = gap;
            end else begin
                gcnt--;
            end
            @(posedge clk_i); lat++; guard++; @(negedge clk_i);
        end
        if (guard >= 600) check("w_timeout", 0, 1);
        wd_valid_i = 0; wready_i = 0;
        bvalid_i = 1; bresp_i = bresp;
        #1;
        check("bready", 64'(bready_o), 1);
        check("b_w_quiet", 64'({wvalid_o, wd_ready_o}), 0);
        @(posedge clk_i); lat++; @(negedge clk_i);
        bvalid_i = 0; bresp_i = 0;
        #1;
        check("wr_done", 64'(done_o), 1);
        check("wr_err", 64'(err_o), 64'(exp_err));
        if (gap == 0) check("wr_latency", 64'(lat + 1), 64'(4 + int'(len)));
        @(negedge clk_i);
        #1;
        check("wr_done_pulse", 64'(done_o), 0);
        check("wr_idle_ready", 64'(req_ready_o), 1);
        sb_q.delete();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_i = 1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 0;
        #1;
        check("reset_req_ready", 64'(req_ready_o), 1);
        check("reset_valids", 64'({arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o,
                                   rd_valid_o, wd_ready_o, done_o, err_o}), 0);
        check("reset_regs", 64'({araddr_o, arlen_o, arsize_o}), 0);

        run_read(32'h100, 8'd0, 1'b0, -1, -1, 0, 1'b0);
        run_read(32'h200, 8'd3, 1'b1, -1, -1, 0, 1'b0);
        run_write(32'h300, 8'd3, 2, 2'b00, 1'b0, -1);
        run_write(32'h400, 8'd1, 0, 2'b00, 1'b0, -1);
        run_write(32'h500, 8'd0, 0, 2'b10, 1'b1, -1);
        run_read(32'h600, 8'd3, 1'b0, 1, -1, 0, 1'b1);
        run_read(32'h700, 8'd3, 1'b0, -1, 2, 0, 1'b1);
        run_read(32'h800, 8'd1, 1'b0, -1, -1, 5, 1'b0);
        run_write(32'h900, 8'd3, 0, 2'b00, 1'b0, 2);
        run_read(32'hA00, 8'd2, 1'b0, -1, -1, 0, 1'b0);
        run_read(32'h1000, 8'd255, 1'b0, -1, -1, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
